// File: rtl/obi_icn_pkg.sv
// Shared definitions for the OBI interconnect arbiter: FSM state encoding
// and default configuration values.
package obi_icn_pkg;

   localparam int NUM_INIT_DEF       = 2;
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // ERR exists only when the response timeout is compiled in.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
      , ERR = 2'd3
`endif
   } state_e;

endpackage

// File: rtl/obi_icn_rr_pick.sv
// Combinational round-robin picker. The search starts at the index just
// above ptr and wraps, so the last-served initiator has lowest priority.
module obi_icn_rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic                 valid
);

   localparam int PW = $clog2(N);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   // Walk the candidates in rotated order and take the first requester.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path through the block can infer a latch.
      grant = '0;
      valid = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int off = 1; off <= N; off++) begin
         // Width PW+1 holds ptr+off (at most 2N-1) without overflow.
         sum = {1'b0, ptr} + (PW+1)'(off);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/obi_icn_arbiter.sv
// N-to-1 OBI arbiter with one outstanding transaction. Requests are granted
// round-robin in IDLE, replayed to the target from latched copies in REQ, and
// the response is routed back combinationally in RSP.
// Optional response timeout: define OBI_ICN_ARBITER_TIMEOUT_EN to add a
// counter and an ERR state that answers the initiator with an error.
module obi_icn_arbiter
   import obi_icn_pkg::*;
#(
   parameter int OBI_AW         = 32,
   parameter int OBI_DW         = 32,
   parameter int OBI_IDW        = 1,
   parameter int NUM_INIT       = NUM_INIT_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_INIT-1:0]                   s_req,
   input  logic [NUM_INIT-1:0]                   s_we,
   input  logic [NUM_INIT-1:0][OBI_AW-1:0]       s_addr,
   input  logic [NUM_INIT-1:0][OBI_DW/8-1:0]     s_be,
   input  logic [NUM_INIT-1:0][OBI_DW-1:0]       s_wdata,
   input  logic [NUM_INIT-1:0][OBI_IDW-1:0]      s_aid,
   input  logic [NUM_INIT-1:0]                   s_rready,
   output logic [NUM_INIT-1:0]                   s_gnt,
   output logic [NUM_INIT-1:0]                   s_gntpar,
   output logic [NUM_INIT-1:0]                   s_rvalid,
   output logic [NUM_INIT-1:0]                   s_rvalidpar,
   output logic [NUM_INIT-1:0]                   s_err,
   output logic [OBI_DW-1:0]                     s_rdata,
   output logic [OBI_IDW-1:0]                    s_rid,
   output logic                                  m_req,
   output logic                                  m_reqpar,
   output logic                                  m_we,
   output logic [OBI_AW-1:0]                     m_addr,
   output logic [OBI_DW/8-1:0]                   m_be,
   output logic [OBI_DW-1:0]                     m_wdata,
   output logic [OBI_IDW-1:0]                    m_aid,
   output logic                                  m_rready,
   output logic                                  m_rreadypar,
   input  logic                                  m_gnt,
   input  logic                                  m_rvalid,
   input  logic                                  m_err,
   input  logic [OBI_DW-1:0]                     m_rdata,
   input  logic [OBI_IDW-1:0]                    m_rid
);

   localparam int PW = $clog2(NUM_INIT);
   localparam int BW = OBI_DW / 8;

   state_e              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic                latch_en;
   logic                we_q;
   logic [OBI_AW-1:0]   addr_q;
   logic [BW-1:0]       be_q;
   logic [OBI_DW-1:0]   wdata_q;
   logic [OBI_IDW-1:0]  aid_q;
   logic [NUM_INIT-1:0] pick_grant;
   logic                pick_valid;
   logic [PW-1:0]       pick_idx;

`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
   logic [15:0]         cnt_q, cnt_d;
`endif

   // With a single outstanding transaction the returned ID is always the
   // latched one, so the target's ID is not needed.
   logic rid_unused;
   assign rid_unused = ^m_rid;

   obi_icn_rr_pick #(.N(NUM_INIT)) u_pick (
      .req   (s_req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // Encode the one-hot winner into an index for the owner register.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_INIT; i++)
         if (pick_grant[i]) pick_idx = PW'(i);
   end

   // Next-state and output decode; everything is held quiet during reset.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      latch_en = 1'b0;
      s_gnt    = '0;
      s_rvalid = '0;
      s_err    = '0;
      s_rdata  = '0;
      s_rid    = '0;
      m_req    = 1'b0;
      m_rready = 1'b1;  // drain stale target responses outside RSP
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      if (reset_n) begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  s_gnt    = pick_grant;
                  latch_en = 1'b1;
                  owner_d  = pick_idx;
                  state_d  = REQ;
               end
            end
            REQ: begin
               m_req = 1'b1;
               if (m_gnt) begin
                  state_d = RSP;
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
            RSP: begin
               s_rvalid[owner_q] = m_rvalid;
               s_err[owner_q]    = m_err;
               s_rdata           = m_rdata;
               s_rid             = aid_q;
               m_rready          = s_rready[owner_q];
               if (m_rvalid && s_rready[owner_q]) begin
                  state_d = IDLE;
                  ptr_d   = owner_q;
               end
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
               else begin
                  cnt_d = cnt_q + 16'd1;
                  if (cnt_d == 16'(TIMEOUT_CYCLES)) state_d = ERR;
               end
`endif
            end
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
            ERR: begin
               s_rvalid[owner_q] = 1'b1;
               s_err[owner_q]    = 1'b1;
               s_rid             = aid_q;
               if (s_rready[owner_q]) begin
                  state_d = IDLE;
                  ptr_d   = owner_q;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // State, pointer and request latches with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample the same pre-edge values.
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NUM_INIT - 1);
         owner_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         aid_q   <= '0;
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
         if (latch_en) begin
            we_q    <= s_we[pick_idx];
            addr_q  <= s_addr[pick_idx];
            be_q    <= s_be[pick_idx];
            wdata_q <= s_wdata[pick_idx];
            aid_q   <= s_aid[pick_idx];
         end
      end
   end

   assign m_we    = we_q;
   assign m_addr  = addr_q;
   assign m_be    = be_q;
   assign m_wdata = wdata_q;
   assign m_aid   = aid_q;

   assign m_reqpar    = ~m_req;
   assign m_rreadypar = ~m_rready;
   assign s_gntpar    = ~s_gnt;
   assign s_rvalidpar = ~s_rvalid;

endmodule

// File: tb/tb_obi_icn_arbiter.sv
// Directed testbench for obi_icn_arbiter (two initiators, 2-bit IDs).
// The timeout scenario is compiled only with OBI_ICN_ARBITER_TIMEOUT_EN.
module tb_obi_icn_arbiter;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [1:0]            s_req, s_we, s_rready;
   logic [1:0][31:0]      s_addr, s_wdata;
   logic [1:0][3:0]       s_be;
   logic [1:0][1:0]       s_aid;
   logic [1:0]            s_gnt, s_gntpar, s_rvalid, s_rvalidpar, s_err;
   logic [31:0]           s_rdata;
   logic [1:0]            s_rid;
   logic                  m_req, m_reqpar, m_we, m_rready, m_rreadypar;
   logic [31:0]           m_addr, m_wdata;
   logic [3:0]            m_be;
   logic [1:0]            m_aid;
   logic                  m_gnt, m_rvalid, m_err;
   logic [31:0]           m_rdata;
   logic [1:0]            m_rid;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   obi_icn_arbiter #(
      .OBI_AW(32), .OBI_DW(32), .OBI_IDW(2), .NUM_INIT(2), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
      .s_aid(s_aid), .s_rready(s_rready),
      .s_gnt(s_gnt), .s_gntpar(s_gntpar), .s_rvalid(s_rvalid), .s_rvalidpar(s_rvalidpar),
      .s_err(s_err), .s_rdata(s_rdata), .s_rid(s_rid),
      .m_req(m_req), .m_reqpar(m_reqpar), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
      .m_wdata(m_wdata), .m_aid(m_aid), .m_rready(m_rready), .m_rreadypar(m_rreadypar),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata), .m_rid(m_rid)
   );

   // Inputs change 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Outputs are sampled on the falling edge.
   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      s_req = '0; s_we = '0; s_rready = 2'b11;
      s_addr = '0; s_wdata = '0; s_be = '0; s_aid = '0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0; m_rid = '0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      idle_inputs();
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0; s_req = 2'b11; m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'h1234_5678;
      next_cycle();
      settle();
      n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL rst_m_req: got %b want 0", m_req); end
      n_cmp++; if (m_reqpar !== 1'b1) begin n_mis++; $display("FAIL rst_m_reqpar: got %b want 1", m_reqpar); end
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL rst_s_gnt: got %b want 00", s_gnt); end
      n_cmp++; if (s_gntpar !== 2'b11) begin n_mis++; $display("FAIL rst_s_gntpar: got %b want 11", s_gntpar); end
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL rst_s_rvalid: got %b want 00", s_rvalid); end
      n_cmp++; if (s_rvalidpar !== 2'b11) begin n_mis++; $display("FAIL rst_s_rvalidpar: got %b want 11", s_rvalidpar); end
      n_cmp++; if (s_err !== 2'b00) begin n_mis++; $display("FAIL rst_s_err: got %b want 00", s_err); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL rst_m_rready: got %b want 1", m_rready); end
      n_cmp++; if (m_rreadypar !== 1'b0) begin n_mis++; $display("FAIL rst_m_rreadypar: got %b want 0", m_rreadypar); end
      n_cmp++; if (s_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_s_rdata: got %h want 0", s_rdata); end
      next_cycle();
      reset_n = 1'b1;
      idle_inputs();
      settle();
      n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL post_rst_m_req: got %b want 0", m_req); end
      n_cmp++; if (m_addr !== 32'h0) begin n_mis++; $display("FAIL post_rst_m_addr: got %h want 0", m_addr); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL post_rst_m_rready: got %b want 1", m_rready); end
   endtask

   // Minimum-latency read: gnt at N, m_req at N+1, rvalid at N+2.
   task automatic test_basic_read();
      next_cycle();
      s_req = 2'b01; s_we = 2'b00; s_addr[0] = 32'h0105_0004; s_be[0] = 4'hF; s_aid[0] = 2'd2;
      settle();
      n_cmp++; if (s_gnt !== 2'b01) begin n_mis++; $display("FAIL basic_gnt: got %b want 01", s_gnt); end
      n_cmp++; if (s_gntpar !== 2'b10) begin n_mis++; $display("FAIL basic_gntpar: got %b want 10", s_gntpar); end
      n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL basic_m_req_n: got %b want 0", m_req); end
      next_cycle();
      s_req = 2'b00; m_gnt = 1'b1;
      settle();
      n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL basic_m_req: got %b want 1", m_req); end
      n_cmp++; if (m_reqpar !== 1'b0) begin n_mis++; $display("FAIL basic_m_reqpar: got %b want 0", m_reqpar); end
      n_cmp++; if (m_addr !== 32'h0105_0004) begin n_mis++; $display("FAIL basic_m_addr: got %h want 01050004", m_addr); end
      n_cmp++; if (m_we !== 1'b0) begin n_mis++; $display("FAIL basic_m_we: got %b want 0", m_we); end
      n_cmp++; if (m_be !== 4'hF) begin n_mis++; $display("FAIL basic_m_be: got %h want f", m_be); end
      n_cmp++; if (m_aid !== 2'd2) begin n_mis++; $display("FAIL basic_m_aid: got %0d want 2", m_aid); end
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL basic_gnt_req: got %b want 00", s_gnt); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
      settle();
      n_cmp++; if (s_rvalid !== 2'b01) begin n_mis++; $display("FAIL basic_rvalid: got %b want 01", s_rvalid); end
      n_cmp++; if (s_rvalidpar !== 2'b10) begin n_mis++; $display("FAIL basic_rvalidpar: got %b want 10", s_rvalidpar); end
      n_cmp++; if (s_rdata !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL basic_rdata: got %h want cafef00d", s_rdata); end
      n_cmp++; if (s_rid !== 2'd2) begin n_mis++; $display("FAIL basic_rid: got %0d want 2", s_rid); end
      n_cmp++; if (s_err !== 2'b00) begin n_mis++; $display("FAIL basic_err: got %b want 00", s_err); end
      n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL basic_m_req_rsp: got %b want 0", m_req); end
      next_cycle();
      idle_inputs();
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL basic_rvalid_done: got %b want 00", s_rvalid); end
   endtask

   // Both initiators request continuously; zero-wait target, 3 cycles per transaction.
   task automatic test_round_robin();
      logic [1:0]  exp_oh;
      logic [31:0] exp_addr;
      int          txn;
      apply_reset();
      s_req = 2'b11; s_addr[0] = 32'h1000_0000; s_addr[1] = 32'h2000_0000;
      m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BAD_BEEF;
      for (int k = 0; k < 12; k++) begin
         txn      = k / 3;
         exp_oh   = (txn % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (txn % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000;
         settle();
         case (k % 3)
            0: begin
               n_cmp++; if (s_gnt !== exp_oh) begin n_mis++; $display("FAIL rr_gnt[%0d]: got %b want %b", txn, s_gnt, exp_oh); end
               n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL rr_m_req_idle[%0d]: got %b want 0", txn, m_req); end
            end
            1: begin
               n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL rr_m_req[%0d]: got %b want 1", txn, m_req); end
               n_cmp++; if (m_addr !== exp_addr) begin n_mis++; $display("FAIL rr_m_addr[%0d]: got %h want %h", txn, m_addr, exp_addr); end
               n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL rr_gnt_busy[%0d]: got %b want 00", txn, s_gnt); end
            end
            default: begin
               n_cmp++; if (s_rvalid !== exp_oh) begin n_mis++; $display("FAIL rr_rvalid[%0d]: got %b want %b", txn, s_rvalid, exp_oh); end
               n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL rr_m_req_rsp[%0d]: got %b want 0", txn, m_req); end
            end
         endcase
         next_cycle();
      end
      idle_inputs();
      settle();
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL rr_gnt_end: got %b want 00", s_gnt); end
   endtask

   // Target withholds m_gnt for 5 cycles; request must stay stable and no regrant.
   task automatic test_gnt_stall();
      next_cycle();
      s_req = 2'b11; s_we = 2'b01; s_addr[0] = 32'h3000_0040; s_wdata[0] = 32'hA5A5_5A5A;
      s_be[0] = 4'b0011; s_aid[0] = 2'd1;
      settle();
      n_cmp++; if (s_gnt !== 2'b01) begin n_mis++; $display("FAIL stall_gnt: got %b want 01", s_gnt); end
      next_cycle();
      s_addr[0] = 32'hFFFF_FFFF; s_wdata[0] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL stall_m_req[%0d]: got %b want 1", i, m_req); end
         n_cmp++; if (m_addr !== 32'h3000_0040) begin n_mis++; $display("FAIL stall_m_addr[%0d]: got %h want 30000040", i, m_addr); end
         n_cmp++; if (m_wdata !== 32'hA5A5_5A5A) begin n_mis++; $display("FAIL stall_m_wdata[%0d]: got %h want a5a55a5a", i, m_wdata); end
         n_cmp++; if (m_we !== 1'b1) begin n_mis++; $display("FAIL stall_m_we[%0d]: got %b want 1", i, m_we); end
         n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL stall_regnt[%0d]: got %b want 00", i, s_gnt); end
         next_cycle();
      end
      m_gnt = 1'b1;
      settle();
      n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL stall_m_req_gnt: got %b want 1", m_req); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
      settle();
      n_cmp++; if (s_rvalid !== 2'b01) begin n_mis++; $display("FAIL stall_rvalid: got %b want 01", s_rvalid); end
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL stall_gnt_rsp: got %b want 00", s_gnt); end
      next_cycle();
      idle_inputs();
      settle();
   endtask

   // Initiator 1 holds off s_rready for 3 cycles while the target has a response.
   task automatic test_backpressure();
      int deliveries = 0;
      next_cycle();
      s_req = 2'b10; s_aid[1] = 2'd3; s_addr[1] = 32'h4000_0008;
      settle();
      n_cmp++; if (s_gnt !== 2'b10) begin n_mis++; $display("FAIL bp_gnt: got %b want 10", s_gnt); end
      next_cycle();
      s_req = 2'b00; m_gnt = 1'b1;
      settle();
      n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL bp_m_req: got %b want 1", m_req); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'h1111_2222; s_rready = 2'b01;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_cmp++; if (m_rready !== 1'b0) begin n_mis++; $display("FAIL bp_m_rready[%0d]: got %b want 0", i, m_rready); end
         n_cmp++; if (m_rreadypar !== 1'b1) begin n_mis++; $display("FAIL bp_m_rreadypar[%0d]: got %b want 1", i, m_rreadypar); end
         n_cmp++; if (s_rvalid !== 2'b10) begin n_mis++; $display("FAIL bp_rvalid[%0d]: got %b want 10", i, s_rvalid); end
         n_cmp++; if (s_err !== 2'b10) begin n_mis++; $display("FAIL bp_err[%0d]: got %b want 10", i, s_err); end
         n_cmp++; if (s_rid !== 2'd3) begin n_mis++; $display("FAIL bp_rid[%0d]: got %0d want 3", i, s_rid); end
         if (s_rvalid[1] && s_rready[1]) deliveries++;
         next_cycle();
      end
      s_rready = 2'b11;
      settle();
      n_cmp++; if (s_rvalid !== 2'b10) begin n_mis++; $display("FAIL bp_rvalid_hs: got %b want 10", s_rvalid); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL bp_m_rready_hs: got %b want 1", m_rready); end
      n_cmp++; if (s_rdata !== 32'h1111_2222) begin n_mis++; $display("FAIL bp_rdata: got %h want 11112222", s_rdata); end
      if (s_rvalid[1] && s_rready[1]) deliveries++;
      next_cycle();
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL bp_stale_rvalid: got %b want 00", s_rvalid); end
      n_cmp++; if (s_err !== 2'b00) begin n_mis++; $display("FAIL bp_stale_err: got %b want 00", s_err); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL bp_stale_m_rready: got %b want 1", m_rready); end
      if (s_rvalid[1] && s_rready[1]) deliveries++;
      n_cmp++; if (deliveries !== 1) begin n_mis++; $display("FAIL bp_deliveries: got %0d want 1", deliveries); end
      idle_inputs();
   endtask

   // A request that appears and vanishes while busy never gets granted.
   task automatic test_drop_request();
      next_cycle();
      s_req = 2'b01;
      settle();
      n_cmp++; if (s_gnt !== 2'b01) begin n_mis++; $display("FAIL drop_gnt0: got %b want 01", s_gnt); end
      next_cycle();
      s_req = 2'b10;
      settle();
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL drop_gnt_busy: got %b want 00", s_gnt); end
      next_cycle();
      s_req = 2'b00; m_gnt = 1'b1;
      settle();
      n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL drop_m_req: got %b want 1", m_req); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1;
      settle();
      n_cmp++; if (s_rvalid !== 2'b01) begin n_mis++; $display("FAIL drop_rvalid: got %b want 01", s_rvalid); end
      next_cycle();
      m_rvalid = 1'b0;
      settle();
      n_cmp++; if (s_gnt !== 2'b00) begin n_mis++; $display("FAIL drop_gnt_idle: got %b want 00", s_gnt); end
      next_cycle();
      settle();
      n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL drop_m_req_idle: got %b want 0", m_req); end
      n_cmp++; if (s_err !== 2'b00) begin n_mis++; $display("FAIL drop_err: got %b want 00", s_err); end
   endtask

   // Reset while waiting in RSP abandons the transaction; initiator 0 wins next.
   task automatic test_reset_mid_rsp();
      next_cycle();
      s_req = 2'b10;
      settle();
      n_cmp++; if (s_gnt !== 2'b10) begin n_mis++; $display("FAIL mrst_gnt: got %b want 10", s_gnt); end
      next_cycle();
      s_req = 2'b00; m_gnt = 1'b1;
      settle();
      next_cycle();
      m_gnt = 1'b0;
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL mrst_rsp_wait: got %b want 00", s_rvalid); end
      next_cycle();
      reset_n = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777_0000;
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL mrst_rvalid_in_rst: got %b want 00", s_rvalid); end
      n_cmp++; if (s_rdata !== 32'h0) begin n_mis++; $display("FAIL mrst_rdata_in_rst: got %h want 0", s_rdata); end
      next_cycle();
      reset_n = 1'b1; s_req = 2'b11;
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL mrst_rvalid_after: got %b want 00", s_rvalid); end
      n_cmp++; if (s_gnt !== 2'b01) begin n_mis++; $display("FAIL mrst_first_gnt: got %b want 01", s_gnt); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL mrst_drain: got %b want 1", m_rready); end
      next_cycle();
      s_req = 2'b00; m_rvalid = 1'b0; m_gnt = 1'b1;
      settle();
      n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL mrst_m_req: got %b want 1", m_req); end
      next_cycle();
      m_gnt = 1'b0; m_rvalid = 1'b1;
      settle();
      n_cmp++; if (s_rvalid !== 2'b01) begin n_mis++; $display("FAIL mrst_rvalid0: got %b want 01", s_rvalid); end
      next_cycle();
      idle_inputs();
      settle();
   endtask

`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
   // Target never answers: 8 RSP cycles, then an error response with zero data.
   task automatic test_timeout();
      next_cycle();
      s_req = 2'b01; s_aid[0] = 2'd2;
      settle();
      n_cmp++; if (s_gnt !== 2'b01) begin n_mis++; $display("FAIL to_gnt: got %b want 01", s_gnt); end
      next_cycle();
      s_req = 2'b00;
      for (int i = 0; i < 10; i++) begin
         settle();
         n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL to_req_hold[%0d]: got %b want 1", i, m_req); end
         n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL to_req_rvalid[%0d]: got %b want 00", i, s_rvalid); end
         next_cycle();
      end
      m_gnt = 1'b1; s_rready = 2'b00;
      settle();
      next_cycle();
      m_gnt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         settle();
         n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL to_rsp_rvalid[%0d]: got %b want 00", i, s_rvalid); end
         n_cmp++; if (m_rready !== 1'b0) begin n_mis++; $display("FAIL to_rsp_m_rready[%0d]: got %b want 0", i, m_rready); end
         next_cycle();
      end
      m_rdata = 32'hDEAD_BEEF;
      settle();
      n_cmp++; if (s_rvalid !== 2'b01) begin n_mis++; $display("FAIL to_err_rvalid: got %b want 01", s_rvalid); end
      n_cmp++; if (s_err !== 2'b01) begin n_mis++; $display("FAIL to_err_err: got %b want 01", s_err); end
      n_cmp++; if (s_rdata !== 32'h0) begin n_mis++; $display("FAIL to_err_rdata: got %h want 0", s_rdata); end
      n_cmp++; if (s_rid !== 2'd2) begin n_mis++; $display("FAIL to_err_rid: got %0d want 2", s_rid); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL to_err_m_rready: got %b want 1", m_rready); end
      next_cycle();
      s_rready = 2'b01;
      settle();
      n_cmp++; if (s_err !== 2'b01) begin n_mis++; $display("FAIL to_err_hold: got %b want 01", s_err); end
      next_cycle();
      s_rready = 2'b11; m_rvalid = 1'b1;
      settle();
      n_cmp++; if (s_rvalid !== 2'b00) begin n_mis++; $display("FAIL to_late_rvalid: got %b want 00", s_rvalid); end
      n_cmp++; if (s_err !== 2'b00) begin n_mis++; $display("FAIL to_late_err: got %b want 00", s_err); end
      n_cmp++; if (m_rready !== 1'b1) begin n_mis++; $display("FAIL to_late_m_rready: got %b want 1", m_rready); end
      next_cycle();
      idle_inputs();
      settle();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_read();
      test_round_robin();
      test_gnt_stall();
      test_backpressure();
      test_drop_request();
      test_reset_mid_rsp();
`ifdef OBI_ICN_ARBITER_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
